// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: none (definitions only).
// Backpressure: not applicable.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the imem req/gnt/rvalid bus, the decode valid/ready port and the redirect port.
// Latency: none (wires only).
// Backpressure: carried by imem_gnt_i and instr_ready_i.
interface instr_fetch_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, pc_plus4_o, instr_valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, pc_o, pc_plus4_o, instr_valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/pc_next.sv
// Next-PC select: aligned redirect target, pc+4 on consume, otherwise hold.
// Latency: combinational.
// Backpressure: hold is selected whenever the current instruction is not consumed.
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        advance_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_next_o
);

  // Redirect wins over sequential advance; PC wraps modulo 2^32.
  always_comb begin
    pc_next_o = pc_i;
    if (redirect_i) begin
      pc_next_o = word_align(redirect_pc_i);
    end else if (advance_i) begin
      pc_next_o = pc_i + 32'd4;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, issues one imem request at a time, hands words to decode.
// Latency: REQ with gnt -> rvalid next cycle -> instr_valid_o the cycle after (1 instr / 3 cycles peak).
// Backpressure: VALID holds instr_o/pc_o and issues no new request until instr_ready_i.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic clk_i,
  input  logic rst_i,
  instr_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         kill_q, kill_d;
  logic         advance;

  assign advance = (state_q == VALID) && bus.instr_ready_i;

  pc_next u_pc_next (
    .pc_i          (pc_q),
    .advance_i     (advance),
    .redirect_i    (bus.redirect_i),
    .redirect_pc_i (bus.redirect_pc_i),
    .pc_next_o     (pc_d)
  );

  // State, PC, kill flag and instruction registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      kill_q  <= kill_d;
    end
  end

  // Next state; kill marks a granted fetch whose data must be thrown away.
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.imem_gnt_i) begin
          state_d = WAIT;
          kill_d  = bus.redirect_i;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid_i) begin
          kill_d = 1'b0;
          if (kill_q || bus.redirect_i) begin
            state_d = REQ;
          end else begin
            instr_d = bus.imem_rdata_i;
            state_d = VALID;
          end
        end else if (bus.redirect_i) begin
          kill_d = 1'b1;
        end
      end
      VALID: begin
        if (bus.redirect_i || bus.instr_ready_i) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req_o    = (state_q == REQ);
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = (state_q == VALID);
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.pc_plus4_o    = pc_q + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: two instances (reset PC 0 and 0xFFFF_FFFC) share stimulus.
// A PC-sequence reference model predicts every presented instruction and every request address.
// A bench memory model answers req/gnt/rvalid with programmable delays and stale responses.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        gnt, rvalid, ready, redirect;
  logic [31:0] rdata, redirect_pc;

  instr_fetch_if if0 ();
  instr_fetch_if if1 ();

  assign if0.imem_gnt_i    = gnt;
  assign if0.imem_rvalid_i = rvalid;
  assign if0.imem_rdata_i  = rdata;
  assign if0.instr_ready_i = ready;
  assign if0.redirect_i    = redirect;
  assign if0.redirect_pc_i = redirect_pc;
  assign if1.imem_gnt_i    = gnt;
  assign if1.imem_rvalid_i = rvalid;
  assign if1.imem_rdata_i  = rdata;
  assign if1.instr_ready_i = ready;
  assign if1.redirect_i    = redirect;
  assign if1.redirect_pc_i = redirect_pc;

  instr_fetch u_dut0 (.clk_i(clk), .rst_i(rst_n), .bus(if0.master));
  instr_fetch #(.RESET_PC(RPC1)) u_dut1 (.clk_i(clk), .rst_i(rst_n), .bus(if1.master));

  logic        m_req, m_vld;
  logic [31:0] m_addr, m_instr, m_pc, m_pc4;
  assign m_req   = sel ? if1.imem_req_o    : if0.imem_req_o;
  assign m_vld   = sel ? if1.instr_valid_o : if0.instr_valid_o;
  assign m_addr  = sel ? if1.imem_addr_o   : if0.imem_addr_o;
  assign m_instr = sel ? if1.instr_o       : if0.instr_o;
  assign m_pc    = sel ? if1.pc_o          : if0.pc_o;
  assign m_pc4   = sel ? if1.pc_plus4_o    : if0.pc_plus4_o;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit best_mode = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0093;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] cur, rpc;
  bit          cur_vld, prev_vld, prev_rst;
  int          cyc, last_pres, stall_cnt;

  initial begin
    cur_vld = 0; prev_vld = 0; prev_rst = 0; cur = '0;
    cyc = 0; last_pres = -1; stall_cnt = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      rpc = sel ? RPC1 : 32'h0;
      if (!rst_n) begin
        chk("rst_req",    32'(m_req), 32'd0);
        chk("rst_vld",    32'(m_vld), 32'd0);
        chk("rst_instr",  m_instr, NOP_INSTR);
        chk("rst_addr",   m_addr, rpc);
        chk("rst_pc",     m_pc, rpc);
        chk("rst_pc4",    m_pc4, rpc + 32'd4);
        exp_q.delete();
        exp_q.push_back(rpc);
        cur_vld = 0; prev_vld = 0; prev_rst = 0;
        cyc = 0; last_pres = -1; stall_cnt = 0;
      end else begin
        cyc++;
        stall_cnt++;
        if (!prev_rst) chk("boot_req", 32'(m_req), 32'd1);
        prev_rst = 1;
        // Apply what the last clock edge did to the expected PC sequence.
        if (redirect) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc & 32'hFFFF_FFFC);
          cur_vld = 0;
        end else if (prev_vld && ready) begin
          exp_q.delete();
          exp_q.push_back(cur + 32'd4);
          cur_vld = 0;
        end
        if (m_vld) begin
          if (!cur_vld) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_valid", 32'(m_vld), 32'd0);
              cur = m_pc;
            end else begin
              cur = exp_q.pop_front();
              if (best_mode) begin
                if (last_pres < 0) chk("boot_latency", 32'(cyc), 32'd3);
                else               chk("peak_interval", 32'(cyc - last_pres), 32'd3);
              end
            end
            cur_vld = 1;
            last_pres = cyc;
            stall_cnt = 0;
          end
          chk("pc_o",       m_pc, cur);
          chk("instr_o",    m_instr, mem_word(cur));
          chk("pc_plus4_o", m_pc4, cur + 32'd4);
        end else if (cur_vld) begin
          chk("valid_dropped", 32'(m_vld), 32'd1);
          cur_vld = 0;
        end
        if (m_req) begin
          chk("req_during_valid", 32'(cur_vld), 32'd0);
          if (exp_q.size() > 0) chk("imem_addr_o", m_addr, exp_q[0]);
        end
        if (stall_cnt > 200) begin
          chk("progress_timeout", 32'(stall_cnt), 32'd0);
          stall_cnt = 0;
        end
        prev_vld = m_vld;
      end
    end
  end

  // ---------------- stimulus + memory model ----------------
  int gmin_t[4]  = '{0, 0, 3, 0};
  int gmax_t[4]  = '{0, 0, 3, 3};
  int rvmin_t[4] = '{0, 0, 4, 0};
  int rvmax_t[4] = '{0, 0, 4, 4};
  int rdy_t[4]   = '{100, 20, 70, 60};
  int redir_t[4] = '{0, 0, 0, 8};
  int rstp_t[4]  = '{0, 0, 0, 4};

  bit          outstanding, redirect_prev;
  logic [31:0] gaddr;
  int          g_dly, rv_dly, rst_hold;

  initial begin
    sel = 0; gnt = 0; rvalid = 0; rdata = '0; ready = 0; redirect = 0; redirect_pc = '0;
    outstanding = 0; redirect_prev = 0; gaddr = '0; g_dly = 0; rv_dly = 0; rst_hold = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk); #2;
      sel = s[0];
      rst_n = 1'b0;
      outstanding = 0; gnt = 0; rvalid = 0; redirect = 0; redirect_prev = 0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      for (int p = 0; p < 4; p++) begin
        best_mode = (p == 0);
        g_dly = $urandom_range(gmax_t[p], gmin_t[p]);
        repeat (300) begin
          @(negedge clk); #2;
          if (!rst_n) begin
            if (rst_hold == 0) rst_n = 1'b1;
            else rst_hold--;
          end
          gnt = 0; rvalid = 0; rdata = $urandom;
          if (outstanding) begin
            if (rv_dly == 0) begin
              rvalid = 1; rdata = mem_word(gaddr); outstanding = 0;
            end else begin
              rv_dly--;
            end
          end else if (m_req) begin
            if (g_dly == 0) begin
              gnt = 1; gaddr = m_addr; outstanding = 1;
              rv_dly = $urandom_range(rvmax_t[p], rvmin_t[p]);
              g_dly  = $urandom_range(gmax_t[p], gmin_t[p]);
            end else begin
              g_dly--;
            end
          end else if ($urandom_range(9, 0) == 0) begin
            rvalid = 1;
          end
          ready = ($urandom_range(99, 0) < rdy_t[p]);
          redirect = 0;
          if (!redirect_prev && $urandom_range(99, 0) < redir_t[p]) begin
            redirect = 1;
            case ($urandom_range(3, 0))
              0:       redirect_pc = 32'h0000_0103;
              1:       redirect_pc = 32'hFFFF_FFFC;
              2:       redirect_pc = 32'hFFFF_FFF8 | 32'($urandom_range(3, 0));
              default: redirect_pc = $urandom;
            endcase
          end
          redirect_prev = redirect;
          if (rst_n && outstanding && $urandom_range(99, 0) < rstp_t[p]) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            rst_hold = 2;
          end
        end
      end
    end
    @(negedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
